// File: rtl/fir_pkg.sv
// Shared definitions for the Wishbone-to-FIR bridge: register offsets,
// control bit positions and the bridge FSM state encoding.
package fir_pkg;

  localparam logic [11:0] OFF_AP_CTRL  = 12'h000;
  localparam logic [11:0] OFF_DATA_LEN = 12'h010;
  localparam logic [11:0] OFF_TAP_BASE = 12'h020;
  localparam logic [11:0] OFF_SS       = 12'h080;
  localparam logic [11:0] OFF_SM       = 12'h084;

  localparam int AP_START_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    LWR,
    LRA,
    LRD,
    SSP,
    SMP,
    ACK
  } state_e;

endpackage

// File: rtl/wb_axi_bridge.sv
// Wishbone slave in front of the FIR block. Each Wishbone cycle becomes
// exactly one AXI-Lite write/read, one AXI-Stream push or one AXI-Stream pop.
// The data-length register is snooped so ss_tlast can mark the last sample.
module wb_axi_bridge
  import fir_pkg::*;
#(
  parameter int         pADDR_WIDTH = 12,
  parameter int         pDATA_WIDTH = 32,
  parameter logic [7:0] pBASE_HI    = 8'h30
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  // Wishbone slave
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [pDATA_WIDTH-1:0] wbs_dat_o,
  // AXI-Lite write
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  // AXI-Lite read
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  // AXI-Stream into FIR
  output logic                   ss_tvalid,
  input  logic                   ss_tready,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  // AXI-Stream out of FIR
  input  logic                   sm_tvalid,
  output logic                   sm_tready,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast
);

  localparam logic [pDATA_WIDTH-1:0] ONE = 1;

  state_e                   state_q, state_d;
  logic [pADDR_WIDTH-1:0]   off_q;
  logic [pDATA_WIDTH-1:0]   data_q;
  logic                     aw_done_q;
  logic                     w_done_q;
  logic [pDATA_WIDTH-1:0]   dat_q;
  logic [pDATA_WIDTH-1:0]   len_q;
  logic [pDATA_WIDTH-1:0]   push_cnt_q;

  logic                     req;
  logic [pADDR_WIDTH-1:0]   off;
  logic                     aw_ok;
  logic                     w_ok;
  logic                     unusedInputs;

  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == pBASE_HI);
  assign off = wbs_adr_i[pADDR_WIDTH-1:0];

  // Byte selects, sm_tlast and the middle address bits carry no meaning here.
  assign unusedInputs = ^{wbs_sel_i, wbs_adr_i[23:pADDR_WIDTH], sm_tlast};

  // A write channel counts as done once it has handshaken, now or earlier.
  assign aw_ok = aw_done_q | (awvalid & awready);
  assign w_ok  = w_done_q  | (wvalid  & wready);

  // State register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: requests are only accepted in IDLE, then the FSM
  // waits as long as the FIR needs for the matching handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (off < OFF_SS)                     state_d = wbs_we_i ? LWR : LRA;
          else if (off == OFF_SS && wbs_we_i)   state_d = SSP;
          else if (off == OFF_SM && !wbs_we_i)  state_d = SMP;
          else                                  state_d = ACK;
        end
      end
      LWR:     if (aw_ok && w_ok) state_d = ACK;
      LRA:     if (arready)       state_d = LRD;
      LRD:     if (rvalid)        state_d = ACK;
      SSP:     if (ss_tready)     state_d = ACK;
      SMP:     if (sm_tvalid)     state_d = ACK;
      ACK:                        state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FIR-side valids/readies and the Wishbone ack are pure state decodes.
  always_comb begin
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ss_tvalid = 1'b0;
    sm_tready = 1'b0;
    wbs_ack_o = 1'b0;
    case (state_q)
      LWR: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      LRA:     arvalid   = 1'b1;
      LRD:     rready    = 1'b1;
      SSP:     ss_tvalid = 1'b1;
      SMP:     sm_tready = 1'b1;
      ACK:     wbs_ack_o = 1'b1;
      default: ;
    endcase
  end

  assign awaddr    = off_q;
  assign araddr    = off_q;
  assign wdata     = data_q;
  assign ss_tdata  = data_q;
  assign wbs_dat_o = dat_q;

  // A zero length disables tlast entirely instead of wrapping to all-ones.
  assign ss_tlast = ss_tvalid & (len_q != '0) & (push_cnt_q == (len_q - ONE));

  // Request latching, write-channel bookkeeping, read capture and the
  // length / push-count snoop used for tlast generation.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      off_q      <= '0;
      data_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      dat_q      <= '0;
      len_q      <= '0;
      push_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            off_q     <= off;
            data_q    <= wbs_dat_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (state_d == ACK) dat_q <= '0;
          end
        end
        LWR: begin
          if (awvalid && awready) aw_done_q <= 1'b1;
          if (wvalid && wready)   w_done_q  <= 1'b1;
          if (state_d == ACK) begin
            if (off_q == OFF_DATA_LEN) len_q <= data_q;
            if (off_q == OFF_AP_CTRL && data_q[AP_START_BIT]) push_cnt_q <= '0;
          end
        end
        LRD: begin
          if (rvalid) dat_q <= rdata;
        end
        SSP: begin
          if (ss_tready && push_cnt_q != '1) push_cnt_q <= push_cnt_q + ONE;
        end
        SMP: begin
          if (sm_tvalid) dat_q <= sm_tdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_axi_bridge.sv
// Self-checking bench for wb_axi_bridge. The bench plays both the Wishbone
// master and the FIR; expected read data and tlast values go through queues.
module tb_wb_axi_bridge;
  import fir_pkg::*;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        awvalid, awready, wvalid, wready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata, ss_tdata, sm_tdata;
  logic        arvalid, arready, rvalid, rready;
  logic        ss_tvalid, ss_tready, ss_tlast;
  logic        sm_tvalid, sm_tready, sm_tlast;

  int passCount  = 0;
  int checkCount = 0;

  logic [31:0] expQ[$];
  logic        tlastQ[$];

  wb_axi_bridge dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .ss_tvalid (ss_tvalid),
    .ss_tready (ss_tready),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .sm_tvalid (sm_tvalid),
    .sm_tready (sm_tready),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = 4'hF;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
  endtask

  task automatic wbRelease();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wbWaitAck(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge axis_clk);
      if (wbs_ack_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    axis_rst_n = 1'b0;
    wbRelease();
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
    ss_tready = 0; sm_tvalid = 0; sm_tdata = '0; sm_tlast = 0;
    @(negedge axis_clk);
    @(negedge axis_clk);
    checkCount++; if (wbs_ack_o !== 1'b0) $display("[TB] FAIL reset_ack: got %b want 0", wbs_ack_o); else passCount++;
    checkCount++; if ({awvalid, wvalid, arvalid, rready} !== 4'b0) $display("[TB] FAIL reset_lite: got %b want 0000", {awvalid, wvalid, arvalid, rready}); else passCount++;
    checkCount++; if ({ss_tvalid, sm_tready, ss_tlast} !== 3'b0) $display("[TB] FAIL reset_stream: got %b want 000", {ss_tvalid, sm_tready, ss_tlast}); else passCount++;
    checkCount++; if (wbs_dat_o !== 32'h0) $display("[TB] FAIL reset_dat: got %h want 0", wbs_dat_o); else passCount++;
    checkCount++; if ({awaddr, araddr, wdata, ss_tdata} !== 88'h0) $display("[TB] FAIL reset_busses: got %h want 0", {awaddr, araddr, wdata, ss_tdata}); else passCount++;
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
  endtask

  task automatic test_len_write();
    awready = 1; wready = 1;
    applyStimulus(1'b1, 32'h3000_0010, 32'd600);
    @(negedge axis_clk);
    checkCount++; if ({awvalid, wvalid} !== 2'b11) $display("[TB] FAIL len_valids: got %b want 11", {awvalid, wvalid}); else passCount++;
    checkCount++; if (awaddr !== OFF_DATA_LEN) $display("[TB] FAIL len_awaddr: got %h want %h", awaddr, OFF_DATA_LEN); else passCount++;
    checkCount++; if (wdata !== 32'd600) $display("[TB] FAIL len_wdata: got %0d want 600", wdata); else passCount++;
    checkCount++; if (wbs_ack_o !== 1'b0) $display("[TB] FAIL len_early_ack: got %b want 0", wbs_ack_o); else passCount++;
    @(negedge axis_clk);
    checkCount++; if (wbs_ack_o !== 1'b1) $display("[TB] FAIL len_ack: got %b want 1", wbs_ack_o); else passCount++;
    wbRelease();
    @(negedge axis_clk);
    checkCount++; if ({wbs_ack_o, awvalid, wvalid} !== 3'b0) $display("[TB] FAIL len_after: got %b want 000", {wbs_ack_o, awvalid, wvalid}); else passCount++;
    awready = 0; wready = 0;
  endtask

  task automatic test_tap_write_delayed();
    awready = 1; wready = 0;
    applyStimulus(1'b1, {20'h30000, OFF_TAP_BASE + 12'h004}, 32'hCAFE_0024);
    @(negedge axis_clk);
    checkCount++; if ({awvalid, wvalid} !== 2'b11) $display("[TB] FAIL tap_valids: got %b want 11", {awvalid, wvalid}); else passCount++;
    checkCount++; if (awaddr !== 12'h024) $display("[TB] FAIL tap_awaddr: got %h want 024", awaddr); else passCount++;
    for (int k = 0; k < 3; k++) begin
      @(negedge axis_clk);
      checkCount++; if ({awvalid, wvalid, wbs_ack_o} !== 3'b010) $display("[TB] FAIL tap_wait%0d: got %b want 010", k, {awvalid, wvalid, wbs_ack_o}); else passCount++;
    end
    wready = 1;
    @(negedge axis_clk);
    checkCount++; if (wbs_ack_o !== 1'b1) $display("[TB] FAIL tap_ack: got %b want 1", wbs_ack_o); else passCount++;
    checkCount++; if (wdata !== 32'hCAFE_0024) $display("[TB] FAIL tap_wdata: got %h want cafe0024", wdata); else passCount++;
    wbRelease(); awready = 0; wready = 0;
    @(negedge axis_clk);
    checkCount++; if ({wbs_ack_o, wvalid} !== 2'b00) $display("[TB] FAIL tap_single_ack: got %b want 00", {wbs_ack_o, wvalid}); else passCount++;
  endtask

  task automatic test_ctrl_read();
    logic [31:0] exp;
    arready = 0; rvalid = 0;
    expQ.push_back(32'h4);
    applyStimulus(1'b0, 32'h3000_0000, 32'h0);
    @(negedge axis_clk);
    checkCount++; if ({arvalid, rready} !== 2'b10) $display("[TB] FAIL rd_ar: got %b want 10", {arvalid, rready}); else passCount++;
    checkCount++; if (araddr !== OFF_AP_CTRL) $display("[TB] FAIL rd_araddr: got %h want 000", araddr); else passCount++;
    arready = 1;
    @(negedge axis_clk);
    checkCount++; if ({arvalid, rready, wbs_ack_o} !== 3'b010) $display("[TB] FAIL rd_r: got %b want 010", {arvalid, rready, wbs_ack_o}); else passCount++;
    arready = 0; rvalid = 1; rdata = 32'h4;
    @(negedge axis_clk);
    checkCount++; if (wbs_ack_o !== 1'b1) $display("[TB] FAIL rd_ack: got %b want 1", wbs_ack_o); else passCount++;
    exp = expQ.pop_front();
    checkCount++; if (wbs_dat_o !== exp) $display("[TB] FAIL rd_data: got %h want %h", wbs_dat_o, exp); else passCount++;
    rvalid = 0; rdata = 32'hDEAD_BEEF;
    wbRelease();
    @(negedge axis_clk);
  endtask

  typedef struct {
    logic        isPush;
    logic [11:0] off;
    logic [31:0] data;
    logic        expLast;
  } op_t;

  task automatic test_stream_push();
    op_t ops[$];
    bit  seen;
    logic expLast;
    ops = '{
      '{1'b0, OFF_DATA_LEN, 32'd3, 1'b0},
      '{1'b0, OFF_AP_CTRL,  32'd1, 1'b0},
      '{1'b1, OFF_SS, 32'd1, 1'b0},
      '{1'b1, OFF_SS, 32'd2, 1'b0},
      '{1'b1, OFF_SS, 32'd3, 1'b1},
      '{1'b1, OFF_SS, 32'd4, 1'b0},
      '{1'b0, OFF_AP_CTRL,  32'd1, 1'b0},
      '{1'b1, OFF_SS, 32'd5, 1'b0},
      '{1'b1, OFF_SS, 32'd6, 1'b0},
      '{1'b1, OFF_SS, 32'd7, 1'b1},
      '{1'b0, OFF_DATA_LEN, 32'd0, 1'b0},
      '{1'b1, OFF_SS, 32'd8, 1'b0}
    };
    awready = 1; wready = 1; ss_tready = 0;
    foreach (ops[i]) begin
      if (!ops[i].isPush) begin
        applyStimulus(1'b1, {20'h30000, ops[i].off}, ops[i].data);
        wbWaitAck(8, seen);
        checkCount++; if (seen !== 1'b1) $display("[TB] FAIL push_cfg%0d_ack: got %b want 1", i, seen); else passCount++;
      end else begin
        tlastQ.push_back(ops[i].expLast);
        applyStimulus(1'b1, {20'h30000, ops[i].off}, ops[i].data);
        @(negedge axis_clk);
        checkCount++; if (ss_tvalid !== 1'b1 || ss_tdata !== ops[i].data) $display("[TB] FAIL push%0d_data: got v=%b d=%h want v=1 d=%h", i, ss_tvalid, ss_tdata, ops[i].data); else passCount++;
        @(negedge axis_clk);
        expLast = tlastQ.pop_front();
        checkCount++; if (ss_tlast !== expLast) $display("[TB] FAIL push%0d_tlast: got %b want %b", i, ss_tlast, expLast); else passCount++;
        ss_tready = 1;
        @(negedge axis_clk);
        checkCount++; if ({wbs_ack_o, ss_tvalid, ss_tlast} !== 3'b100) $display("[TB] FAIL push%0d_ack: got %b want 100", i, {wbs_ack_o, ss_tvalid, ss_tlast}); else passCount++;
        ss_tready = 0;
      end
      wbRelease();
      @(negedge axis_clk);
    end
    awready = 0; wready = 0;
  endtask

  task automatic test_stream_pop();
    logic [31:0] exp;
    int          readyCycles;
    sm_tvalid = 0;
    expQ.push_back(32'hFFFF_FFF6);
    applyStimulus(1'b0, 32'h3000_0084, 32'h0);
    readyCycles = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge axis_clk);
      if (sm_tready && !wbs_ack_o) readyCycles++;
    end
    checkCount++; if (readyCycles !== 10) $display("[TB] FAIL pop_wait: got %0d want 10", readyCycles); else passCount++;
    sm_tvalid = 1; sm_tdata = 32'hFFFF_FFF6; sm_tlast = 1;
    @(negedge axis_clk);
    checkCount++; if (wbs_ack_o !== 1'b1) $display("[TB] FAIL pop_ack: got %b want 1", wbs_ack_o); else passCount++;
    exp = expQ.pop_front();
    checkCount++; if (wbs_dat_o !== exp) $display("[TB] FAIL pop_data: got %h want %h", wbs_dat_o, exp); else passCount++;
    sm_tvalid = 0; sm_tdata = 32'h1234_5678; sm_tlast = 0;
    wbRelease();
    @(negedge axis_clk);
    checkCount++; if (sm_tready !== 1'b0 || wbs_dat_o !== 32'hFFFF_FFF6) $display("[TB] FAIL pop_hold: got r=%b d=%h want r=0 d=fffffff6", sm_tready, wbs_dat_o); else passCount++;
  endtask

  task automatic test_dummy();
    logic [31:0] exp;
    int          ackCount;
    expQ.push_back(32'h0);
    applyStimulus(1'b0, 32'h3000_0080, 32'h0);
    @(negedge axis_clk);
    checkCount++; if ({wbs_ack_o, arvalid, sm_tready} !== 3'b100) $display("[TB] FAIL dummy_rd: got %b want 100", {wbs_ack_o, arvalid, sm_tready}); else passCount++;
    exp = expQ.pop_front();
    checkCount++; if (wbs_dat_o !== exp) $display("[TB] FAIL dummy_rd_data: got %h want %h", wbs_dat_o, exp); else passCount++;
    wbRelease();
    @(negedge axis_clk);
    applyStimulus(1'b1, 32'h3000_0084, 32'h55);
    @(negedge axis_clk);
    checkCount++; if ({wbs_ack_o, awvalid, ss_tvalid} !== 3'b100) $display("[TB] FAIL dummy_wr: got %b want 100", {wbs_ack_o, awvalid, ss_tvalid}); else passCount++;
    wbRelease();
    @(negedge axis_clk);
    applyStimulus(1'b0, 32'h4000_0000, 32'h0);
    ackCount = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge axis_clk);
      if (wbs_ack_o || arvalid) ackCount++;
    end
    checkCount++; if (ackCount !== 0) $display("[TB] FAIL wrong_base: got %0d want 0", ackCount); else passCount++;
    wbRelease();
    @(negedge axis_clk);
  endtask

  task automatic test_reset_mid_push();
    logic [31:0] exp;
    int          badCount;
    bit          seen;
    ss_tready = 0;
    applyStimulus(1'b1, 32'h3000_0080, 32'h77);
    @(negedge axis_clk);
    checkCount++; if (ss_tvalid !== 1'b1) $display("[TB] FAIL rst_pre_valid: got %b want 1", ss_tvalid); else passCount++;
    #2 axis_rst_n = 1'b0;
    #1;
    checkCount++; if (ss_tvalid !== 1'b0 || ss_tdata !== 32'h0) $display("[TB] FAIL rst_async: got v=%b d=%h want v=0 d=0", ss_tvalid, ss_tdata); else passCount++;
    ss_tready = 1;
    @(negedge axis_clk);
    checkCount++; if (wbs_ack_o !== 1'b0) $display("[TB] FAIL rst_hold_ack: got %b want 0", wbs_ack_o); else passCount++;
    axis_rst_n = 1'b1;
    wbRelease();
    ss_tready = 0;
    badCount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge axis_clk);
      if (wbs_ack_o || ss_tvalid) badCount++;
    end
    checkCount++; if (badCount !== 0) $display("[TB] FAIL rst_no_ack: got %0d want 0", badCount); else passCount++;
    expQ.push_back(32'h0);
    applyStimulus(1'b0, 32'h3000_0200, 32'h0);
    wbWaitAck(4, seen);
    checkCount++; if (seen !== 1'b1) $display("[TB] FAIL rst_after_ack: got %b want 1", seen); else passCount++;
    exp = expQ.pop_front();
    checkCount++; if (wbs_dat_o !== exp) $display("[TB] FAIL rst_after_data: got %h want %h", wbs_dat_o, exp); else passCount++;
    wbRelease();
    @(negedge axis_clk);
  endtask

  // Scenarios run back to back on one continuous simulation.
  initial begin
    test_reset();
    test_len_write();
    test_tap_write_delayed();
    test_ctrl_read();
    test_stream_push();
    test_stream_pop();
    test_dummy();
    test_reset_mid_push();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_axi_bridge.md
Name: wb_axi_bridge

Overview:
- Wishbone slave that sits directly upstream of the FIR block. It turns Caravel user-area Wishbone cycles into the FIR's AXI-Lite config accesses, AXI-Stream input pushes and AXI-Stream output pops.
- It also snoops the data-length register so that it can drive ss_tlast on the final input sample.
- One Wishbone transaction is outstanding at a time; the bridge owns all FIR-side valid/ready driving.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width towards FIR.
- pDATA_WIDTH, 32, data width of Wishbone, AXI-Lite and AXI-Stream.
- pBASE_HI, 8'h30, required value of wbs_adr_i[31:24] for the bridge to respond.

Ports:
- axis_clk  in  1  single clock for Wishbone and FIR sides.
- axis_rst_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte select; ignored, full-word semantics.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- awvalid/awready, awaddr[11:0], wvalid/wready, wdata[31:0]  out/in  AXI-Lite write to FIR.
- arvalid/arready, araddr[11:0], rvalid/rready, rdata[31:0]  out/in  AXI-Lite read from FIR.
- ss_tvalid/ss_tready, ss_tdata[31:0], ss_tlast  out/in  stream into FIR.
- sm_tvalid/sm_tready, sm_tdata[31:0], sm_tlast  in/out  stream out of FIR.

Behaviour:
- Request: req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==pBASE_HI). The offset is off = wbs_adr_i[11:0].
- Decode:
  - off < 0x80: AXI-Lite (0x00 ap_ctrl, 0x10 data_length, 0x20-0x7F taps).
  - off==0x80 with write: stream push.
  - off==0x84 with read: stream pop.
  - Anything else (including a read of 0x80 or a write of 0x84): dummy, acked next cycle, no side effect, wbs_dat_o=0.
- FSM states: IDLE, LWR, LRA, LRD, SSP, SMP, ACK.
  - IDLE with req: latch addr/data/we and go to LWR/LRA/SSP/SMP, or to ACK for a dummy.
  - LWR: awvalid=wvalid=1 with awaddr=off and wdata latched. Each valid drops independently on its own handshake. Go to ACK once both handshakes have occurred (same cycle or different cycles).
  - LRA: arvalid=1 with araddr=off; on arready go to LRD.
  - LRD: rready=1; on rvalid capture rdata into the read register and go to ACK.
  - SSP: ss_tvalid=1 with ss_tdata latched; on ss_tready go to ACK and increment push_cnt.
  - SMP: sm_tready=1; on sm_tvalid capture sm_tdata and go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. wbs_dat_o is held stable from the capture until the next capture.
- Latency: minimum 2 cycles from req to ack (req cycle plus handshake cycle). No timeout; the bridge waits indefinitely on FIR.
- Wishbone rule: the master holds stb until ack. A new req is not sampled in ACK; it is sampled in IDLE only.
- Length snoop:
  - A completed LWR to 0x10 loads len_reg <= wdata.
  - A completed LWR to 0x00 with wdata[0]=1 (ap_start) clears push_cnt to 0.
- Stream tlast:
  - ss_tlast = ss_tvalid & (push_cnt == len_reg-1).
  - len_reg==0 means ss_tlast is never asserted.
  - push_cnt is 32-bit and saturates at all-ones.
- sm_tlast is ignored (not stored).
- Reset (asynchronous, any state, including mid-handshake): state=IDLE; all valids, readies and ack = 0; awaddr, araddr, wdata, ss_tdata and wbs_dat_o = 0; len_reg=0; push_cnt=0. The aborted Wishbone cycle is never acked.
- Simultaneous events:
  - aw and w handshakes may complete in either order or together.
  - An ap_start write and the length write are separate transactions, so there is no same-cycle conflict.

Decomposition:
- Shared package fir_pkg:
  - Offset constants: OFF_AP_CTRL=12'h00, OFF_DATA_LEN=12'h10, OFF_TAP_BASE=12'h20, OFF_SS=12'h80, OFF_SM=12'h84.
  - FSM state enum.
  - AP_START_BIT=0.
- A single module; no sub-module is needed.

Test Plan:
- WB write 0x3000_0010 = 32'd600, FIR awready/wready high -> aw and w handshake in the same cycle, ack 2 cycles after stb, len_reg=600.
- WB write to a tap at offset 0x24 with FIR wready delayed 3 cycles after awready -> awvalid drops first, wvalid holds 3 cycles, single ack after the w handshake.
- WB read 0x3000_0000, FIR returns rdata=32'h4 (idle) -> araddr=0, then rready, wbs_dat_o=32'h4 with ack.
- len=3, ap_start, then 3 writes to 0x80 (data 1,2,3) with ss_tready pulsing -> ss_tlast high only on data 3, push_cnt=3.
- Read 0x84 with sm_tvalid arriving 10 cycles late carrying 32'hFFFF_FFF6 -> sm_tready held 10 cycles, wbs_dat_o=32'hFFFF_FFF6, ack.
- Assert axis_rst_n=0 while in SSP -> ss_tvalid=0 immediately, no ack, state IDLE; a read of 0x200 afterwards -> ack with 0.
